// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Package    : audio_pkg
// Description: Shared sample and stereo-frame types for the I2S audio path.
// Revision   : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

endpackage : audio_pkg
`default_nettype wire

// File: rtl/stereo_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module     : stereo_sample_fifo
// Description: First-word-fall-through synchronous FIFO with flush and level.
// Revision   : 1.0 - initial release
// ============================================================================
module stereo_sample_fifo
    import audio_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = stereo_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int               c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_FULL = (c_AW+1)'(DEPTH);

    T                  r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_level;

    logic              w_do_push;
    logic              w_do_pop;

    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    assign full  = (r_level == c_FULL);
    assign empty = (r_level == '0);
    assign level = r_level;
    assign head  = empty ? T'('0) : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (c_AW+1)'(1);
                2'b01:   r_level <= r_level - (c_AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !rst && !clear) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule : stereo_sample_fifo
`default_nettype wire

// File: rtl/i2s_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module     : i2s_frame_buffer
// Description: Captures one L/R pair per I2S frame into a FWFT FIFO and
//              presents it as a valid/ready stream with drop accounting.
// Revision   : 1.0 - initial release
// ============================================================================
module i2s_frame_buffer
    import audio_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     mclk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     enable,
    input  logic                     ws,
    input  logic [WIDTH-1:0]         rx_data_l,
    input  logic [WIDTH-1:0]         rx_data_r,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [WIDTH-1:0]         m_data_l,
    output logic [WIDTH-1:0]         m_data_r,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              drop_count
);

    localparam logic [15:0] c_DROP_MAX = 16'hFFFF;

    logic       r_ws_q;
    logic       r_overflow;
    logic [15:0] r_drop_count;

    logic       w_frame_evt;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic       w_drop;
    stereo_t    w_push_data;
    stereo_t    w_head;

    // A falling ws edge means the previous left/right pair is complete.
    assign w_frame_evt = r_ws_q & ~ws & enable;
    assign w_pop       = ~w_empty & m_ready;
    assign w_drop      = w_frame_evt & w_full & ~w_pop & ~clear;

    assign w_push_data.l = sample_t'(rx_data_l);
    assign w_push_data.r = sample_t'(rx_data_r);

    stereo_sample_fifo #(
        .DEPTH (DEPTH),
        .T     (stereo_t)
    ) u_fifo (
        .clk       (mclk),
        .rst       (rst),
        .clear     (clear),
        .push      (w_frame_evt),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .level     (level)
    );

    assign m_valid    = ~w_empty;
    assign m_data_l   = WIDTH'(w_head.l);
    assign m_data_r   = WIDTH'(w_head.r);
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

    // ws history survives clear so a falling edge in that cycle is not lost.
    always_ff @(posedge mclk) begin
        if (rst) begin
            r_ws_q <= 1'b0;
        end else begin
            r_ws_q <= ws;
        end
    end

    always_ff @(posedge mclk) begin
        if (rst || clear) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != c_DROP_MAX) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

endmodule : i2s_frame_buffer
`default_nettype wire

// File: tb/tb_i2s_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module     : tb_i2s_frame_buffer
// Description: Directed and randomized checks of i2s_frame_buffer (DEPTH=4).
// Revision   : 1.0 - initial release
// ============================================================================
module tb_i2s_frame_buffer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int HALF  = 24 * 32;

    logic              mclk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic              enable = 1'b1;
    logic              ws = 1'b0;
    logic [WIDTH-1:0]  rx_data_l = '0;
    logic [WIDTH-1:0]  rx_data_r = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [WIDTH-1:0]  m_data_l;
    logic [WIDTH-1:0]  m_data_r;
    logic [2:0]        level;
    logic              overflow;
    logic [15:0]       drop_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 mclk = ~mclk;

    i2s_frame_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .mclk       (mclk),
        .rst        (rst),
        .clear      (clear),
        .enable     (enable),
        .ws         (ws),
        .rx_data_l  (rx_data_l),
        .rx_data_r  (rx_data_r),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data_l   (m_data_l),
        .m_data_r   (m_data_r),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    // Reference model: a queue of captured frames plus drop bookkeeping.
    logic [31:0] mq[$];
    logic        m_ws_q = 1'b0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_drops = '0;

    always @(posedge mclk) begin
        logic evt;
        logic pop;
        if (rst) begin
            mq.delete();
            m_ws_q  <= 1'b0;
            m_ovf   <= 1'b0;
            m_drops <= '0;
        end else begin
            evt = m_ws_q && !ws && enable;
            pop = (mq.size() > 0) && m_ready;
            m_ws_q <= ws;
            if (clear) begin
                mq.delete();
                m_ovf   <= 1'b0;
                m_drops <= '0;
            end else begin
                if (pop) void'(mq.pop_front());
                if (evt) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back({rx_data_l, rx_data_r});
                    end else begin
                        m_ovf <= 1'b1;
                        if (m_drops != 16'hFFFF) m_drops <= m_drops + 16'd1;
                    end
                end
            end
        end
    end

    // Called at a negedge; ws falls HALF cycles in and stays low HALF cycles.
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        ws = 1'b1;
        rx_data_l = l;
        rx_data_r = r;
        repeat (HALF) @(negedge mclk);
        ws = 1'b0;
        repeat (HALF) @(negedge mclk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge mclk);
        n_vec++;
        if ({m_valid, level, overflow, drop_count, m_data_l, m_data_r} !== '0) begin
            n_err++;
            $display("FAIL reset: valid=%b level=%0d ovf=%b drops=%0d l=%h r=%h, required all 0",
                     m_valid, level, overflow, drop_count, m_data_l, m_data_r);
        end
        rst = 1'b0;
        @(negedge mclk);
    endtask

    task automatic test_single_frame;
        ws = 1'b1;
        rx_data_l = 16'h1111;
        rx_data_r = 16'hFFFF;
        repeat (HALF) @(negedge mclk);
        ws = 1'b0;
        n_vec++;
        if (m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_early: m_valid=%b required 0", m_valid);
        end
        @(negedge mclk);
        n_vec++;
        if (m_valid !== 1'b1 || m_data_l !== 16'h1111 || m_data_r !== 16'hFFFF) begin
            n_err++;
            $display("FAIL single_latency: valid=%b l=%h r=%h, required 1 1111 ffff",
                     m_valid, m_data_l, m_data_r);
        end
        m_ready = 1'b1;
        @(negedge mclk);
        m_ready = 1'b0;
        n_vec++;
        if (m_valid !== 1'b0 || level !== 3'd0) begin
            n_err++;
            $display("FAIL single_pop: valid=%b level=%0d, required 0 0", m_valid, level);
        end
        repeat (HALF) @(negedge mclk);
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 6; i++) send_frame(16'(i), 16'(100 + i));
        n_vec++;
        if (level !== 3'd4 || overflow !== 1'b1 || drop_count !== 16'd2) begin
            n_err++;
            $display("FAIL overflow_state: level=%0d ovf=%b drops=%0d, required 4 1 2",
                     level, overflow, drop_count);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (m_valid !== 1'b1 || m_data_l !== 16'(i) || m_data_r !== 16'(100 + i)) begin
                n_err++;
                $display("FAIL overflow_drain%0d: valid=%b l=%0d r=%0d, required 1 %0d %0d",
                         i, m_valid, m_data_l, m_data_r, i, 100 + i);
            end
            m_ready = 1'b1;
            @(negedge mclk);
        end
        m_ready = 1'b0;
        n_vec++;
        if (m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_empty: m_valid=%b required 0", m_valid);
        end
    endtask

    task automatic test_full_push_pop;
        for (int i = 0; i < 4; i++) send_frame(16'(10 + i), 16'(20 + i));
        ws = 1'b1;
        rx_data_l = 16'hA5A5;
        rx_data_r = 16'h5A5A;
        repeat (HALF) @(negedge mclk);
        ws = 1'b0;
        m_ready = 1'b1;
        @(negedge mclk);
        m_ready = 1'b0;
        n_vec++;
        if (level !== 3'd4 || drop_count !== 16'd2 || m_data_l !== 16'd11) begin
            n_err++;
            $display("FAIL full_pushpop: level=%0d drops=%0d head=%0d, required 4 2 11",
                     level, drop_count, m_data_l);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (m_data_l !== ((i == 3) ? 16'hA5A5 : 16'(11 + i))) begin
                n_err++;
                $display("FAIL full_order%0d: l=%h required %h", i, m_data_l,
                         (i == 3) ? 16'hA5A5 : 16'(11 + i));
            end
            m_ready = 1'b1;
            @(negedge mclk);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_ws_high;
        int bad;
        bad = 0;
        ws = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge mclk);
            n_vec++;
            if (m_valid !== 1'b0) begin
                n_err++;
                bad++;
                if (bad < 4) $display("FAIL ws_high cycle %0d: m_valid=%b required 0", i, m_valid);
            end
        end
        enable = 1'b0;
        ws = 1'b0;
        repeat (4) @(negedge mclk);
        enable = 1'b1;
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) send_frame(16'(40 + i), 16'(50 + i));
        n_vec++;
        if (level !== 3'd3) begin
            n_err++;
            $display("FAIL rstmid_fill: level=%0d required 3", level);
        end
        ws = 1'b1;
        repeat (8) @(negedge mclk);
        rst = 1'b1;
        @(negedge mclk);
        rst = 1'b0;
        ws = 1'b0;
        n_vec++;
        if (m_valid !== 1'b0 || level !== 3'd0 || drop_count !== 16'd0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_after: valid=%b level=%0d ovf=%b drops=%0d, required 0 0 0 0",
                     m_valid, level, overflow, drop_count);
        end
        @(negedge mclk);
        n_vec++;
        if (m_valid !== 1'b0 || level !== 3'd0) begin
            n_err++;
            $display("FAIL rstmid_nocapture: valid=%b level=%0d, required 0 0", m_valid, level);
        end
        repeat (HALF) @(negedge mclk);
    endtask

    task automatic test_clear_enable;
        for (int i = 0; i < 5; i++) send_frame(16'(60 + i), 16'(70 + i));
        m_ready = 1'b1;
        repeat (2) @(negedge mclk);
        m_ready = 1'b0;
        n_vec++;
        if (level !== 3'd2 || overflow !== 1'b1 || drop_count !== 16'd1) begin
            n_err++;
            $display("FAIL clear_setup: level=%0d ovf=%b drops=%0d, required 2 1 1",
                     level, overflow, drop_count);
        end
        ws = 1'b1;
        repeat (HALF) @(negedge mclk);
        ws = 1'b0;
        clear = 1'b1;
        @(negedge mclk);
        clear = 1'b0;
        n_vec++;
        if (level !== 3'd0 || m_valid !== 1'b0 || overflow !== 1'b0 || drop_count !== 16'd0) begin
            n_err++;
            $display("FAIL clear_state: level=%0d valid=%b ovf=%b drops=%0d, required 0 0 0 0",
                     level, m_valid, overflow, drop_count);
        end
        enable = 1'b0;
        send_frame(16'h7777, 16'h8888);
        n_vec++;
        if (level !== 3'd0 || m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL disabled_capture: level=%0d valid=%b, required 0 0", level, m_valid);
        end
        enable = 1'b1;
    endtask

    task automatic test_random;
        int mode;
        int bad;
        bad = 0;
        for (int f = 0; f < 12; f++) begin
            mode = $urandom_range(0, 2);
            rx_data_l = 16'($urandom);
            rx_data_r = 16'($urandom);
            ws = 1'b1;
            for (int c = 0; c < 2 * HALF; c++) begin
                n_vec++;
                if (m_valid !== (mq.size() > 0) || level !== 3'(mq.size()) ||
                    overflow !== m_ovf || drop_count !== m_drops ||
                    (mq.size() > 0 && {m_data_l, m_data_r} !== mq[0])) begin
                    n_err++;
                    bad++;
                    if (bad < 6)
                        $display("FAIL random f%0d c%0d: valid=%b level=%0d ovf=%b drops=%0d data=%h, required level=%0d ovf=%b drops=%0d data=%h",
                                 f, c, m_valid, level, overflow, drop_count, {m_data_l, m_data_r},
                                 mq.size(), m_ovf, m_drops, (mq.size() > 0) ? mq[0] : 32'h0);
                end
                if (c == HALF) ws = 1'b0;
                m_ready = (mode == 2) ? 1'b1 :
                          (mode == 1) ? ($urandom_range(0, 999) == 0) : 1'b0;
                clear = ($urandom_range(0, 9999) == 0);
                @(negedge mclk);
            end
        end
        m_ready = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        @(negedge mclk);
        test_reset;
        test_single_frame;
        test_overflow;
        test_full_push_pop;
        test_ws_high;
        test_reset_mid;
        test_clear_enable;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_i2s_frame_buffer
`default_nettype wire
